// File: rtl/fifo_stream_pkg.sv
// ----------------------------------------------------------------------------
// fifo_stream_pkg
//   Shared definitions for the FIFO read-side stream framer:
//     - state_e    : framer FSM state encoding (IDLE=0, STREAM=1, DRAIN=2)
//     - BUF_DEPTH  : number of entries in the elastic output buffer
//     - PTR_W      : width of buffer pointers / occupancy
//     - ptr_inc()  : advance a buffer pointer, wrapping at BUF_DEPTH
// ----------------------------------------------------------------------------
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned PTR_W     = 2;

    // Buffer depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

endpackage : fifo_stream_pkg

// File: rtl/stream_skid_buf.sv
// ----------------------------------------------------------------------------
// stream_skid_buf
//   3-entry circular {data, last} buffer between FIFO read data and the
//   output stream. Push and pop in the same cycle keep occupancy unchanged.
//   The head entry is presented on head_data_o/head_last_o; both read as
//   zero while the buffer is empty.
//
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset (empties the buffer)
//   push_i       in   write {push_data_i, push_last_i} at the tail
//   push_data_i  in   word to store
//   push_last_i  in   frame-end tag travelling with the word
//   pop_i        in   discard the head entry
//   head_data_o  out  head word (zero when empty)
//   head_last_o  out  head frame-end tag (zero when empty)
//   occ_o        out  number of valid entries, 0..3
// ----------------------------------------------------------------------------
module stream_skid_buf #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_last_o,
    output logic [1:0]            occ_o
);
    import fifo_stream_pkg::*;

    logic [DATA_WIDTH-1:0] data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  last_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] occ_q, occ_d;
    logic             do_push;
    logic             do_pop;
    logic             not_empty;

    assign not_empty = (occ_q != '0);

    always_comb begin
        do_pop   = pop_i & not_empty;
        // A full buffer still accepts a push when the head leaves this cycle.
        do_push  = push_i & ((occ_q != PTR_W'(BUF_DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            occ_d = occ_q + PTR_W'(1);
        end else if (!do_push && do_pop) begin
            occ_d = occ_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: entries are only observed while occupied.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            data_q[wr_ptr_q] <= push_data_i;
            last_q[wr_ptr_q] <= push_last_i;
        end
    end

    assign head_data_o = not_empty ? data_q[rd_ptr_q] : '0;
    assign head_last_o = not_empty & last_q[rd_ptr_q];
    assign occ_o       = occ_q;

endmodule : stream_skid_buf

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//   Read-side consumer for the synchronous FIFO. Issues FIFO reads (data
//   returns one cycle after fifo_rd_en_o), buffers the returned words in a
//   3-entry elastic buffer and presents them as a valid/ready stream framed
//   into packets of FRAME_LEN words (or a short packet on flush_i) with
//   m_last_o on the final word. Reads are credit-limited by buffer
//   occupancy plus the in-flight read, so m_ready_i never reaches
//   fifo_rd_en_o combinationally.
//
// Parameters:
//   DATA_WIDTH  word width, must match the FIFO
//   DATA_DEPTH  depth of the attached FIFO
//   CNT_WIDTH   FIFO count width minus one
//   FRAME_LEN   words per full frame, 1..DATA_DEPTH
//
// Ports:
//   clk_i                 in   clock
//   rst_i                 in   synchronous active-high reset
//   fifo_rd_en_o          out  FIFO read request
//   fifo_rd_data_valid_i  in   FIFO read data valid (one cycle after request)
//   fifo_rd_data_i        in   FIFO read data
//   fifo_empty_i          in   FIFO empty flag
//   fifo_elem_cnt_i       in   FIFO occupancy
//   flush_i               in   pulse: emit a short frame of current contents
//   m_valid_o             out  stream valid
//   m_ready_i             in   stream ready
//   m_data_o              out  stream data
//   m_last_o              out  final word of frame
//   busy_o                out  FSM not idle
//   err_o                 out  sticky read-protocol error
// ----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_DEPTH),
    parameter int unsigned FRAME_LEN  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  fifo_rd_en_o,
    input  logic                  fifo_rd_data_valid_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    input  logic [CNT_WIDTH:0]    fifo_elem_cnt_i,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  err_o
);
    import fifo_stream_pkg::*;

    localparam logic [CNT_WIDTH:0] FRAME_LEN_C = (CNT_WIDTH+1)'(FRAME_LEN);
    localparam logic [CNT_WIDTH:0] ONE_C       = (CNT_WIDTH+1)'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH:0]   frame_len_q, frame_len_d;
    logic [CNT_WIDTH:0]   issued_q, issued_d;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic                 err_q;

    logic                 rd_en;
    logic                 req_last;
    logic                 credit_ok;
    logic [2:0]           credit_used;

    logic                 buf_push;
    logic                 buf_pop;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                 buf_last;
    logic [1:0]           buf_occ;

    // Words already committed to the buffer: stored plus the one in flight.
    assign credit_used = {1'b0, buf_occ} + {2'b00, inflight_q};
    assign credit_ok   = (credit_used <= 3'd2);

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        issued_d    = issued_q;
        rd_en       = 1'b0;
        req_last    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                issued_d = '0;
                if (fifo_elem_cnt_i >= FRAME_LEN_C) begin
                    frame_len_d = FRAME_LEN_C;
                    state_d     = ST_STREAM;
                end else if (flush_i && !fifo_empty_i) begin
                    frame_len_d = fifo_elem_cnt_i;
                    state_d     = ST_STREAM;
                end
            end

            ST_STREAM: begin
                rd_en = !fifo_empty_i && credit_ok && (issued_q < frame_len_q);
                if (rd_en) begin
                    req_last = (issued_q == frame_len_q - ONE_C);
                    issued_d = issued_q + ONE_C;
                end
                if (issued_d == frame_len_q) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (m_valid_o && m_ready_i && m_last_o) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            frame_len_q     <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_len_q     <= frame_len_d;
            issued_q        <= issued_d;
            inflight_q      <= rd_en;
            inflight_last_q <= req_last;
            // Read data must arrive exactly when a request is in flight.
            if (fifo_rd_data_valid_i != inflight_q) begin
                err_q <= 1'b1;
            end
        end
    end

    // Unrequested data is flagged as an error but never stored, so a
    // protocol violation cannot corrupt or overflow the buffer.
    assign buf_push = fifo_rd_data_valid_i & inflight_q;
    assign buf_pop  = m_valid_o & m_ready_i;

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (buf_push),
        .push_data_i (fifo_rd_data_i),
        .push_last_i (inflight_last_q),
        .pop_i       (buf_pop),
        .head_data_o (buf_data),
        .head_last_o (buf_last),
        .occ_o       (buf_occ)
    );

    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = (buf_occ != '0);
    assign m_data_o     = buf_data;
    assign m_last_o     = buf_last;
    assign busy_o       = (state_q != ST_IDLE);
    assign err_o        = err_q;

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
//   Self-checking bench for fifo_stream_reader. Contains a behavioural FIFO
//   (queue, one-cycle read latency), a per-cycle vector table for the
//   single-frame and flush sequences, hand-written corner sequences and a
//   randomized run scored against the written word order and fixed framing.
// ----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH);
    localparam int FL    = 4;
    localparam logic H   = 1'b1;
    localparam logic L   = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rd_en;
    logic          fifo_rdv;
    logic [DW-1:0] fifo_rdd;
    logic          fifo_empty;
    logic [CW:0]   fifo_cnt;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          err;

    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          inj_valid;
    logic          model_rdv;
    logic [DW-1:0] model_rdd;
    logic [DW-1:0] fifo_q[$];

    int checks = 0;
    int errors = 0;

    assign fifo_rdv = model_rdv | inj_valid;
    assign fifo_rdd = model_rdd;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .CNT_WIDTH  (CW),
        .FRAME_LEN  (FL)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .fifo_rd_en_o         (rd_en),
        .fifo_rd_data_valid_i (fifo_rdv),
        .fifo_rd_data_i       (fifo_rdd),
        .fifo_empty_i         (fifo_empty),
        .fifo_elem_cnt_i      (fifo_cnt),
        .flush_i              (flush),
        .m_valid_o            (m_valid),
        .m_ready_i            (m_ready),
        .m_data_o             (m_data),
        .m_last_o             (m_last),
        .busy_o               (busy),
        .err_o                (err)
    );

    // Behavioural synchronous FIFO: read data valid one cycle after rd_en.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            model_rdv  <= 1'b0;
            model_rdd  <= '0;
            fifo_cnt   <= '0;
            fifo_empty <= 1'b1;
        end else begin
            model_rdv <= 1'b0;
            if (rd_en && fifo_q.size() > 0) begin
                model_rdd <= fifo_q.pop_front();
                model_rdv <= 1'b1;
            end
            if (wr_en) begin
                fifo_q.push_back(wr_data);
            end
            fifo_cnt   <= (CW+1)'(fifo_q.size());
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          flush;
        logic          ready;
        logic          e_rd;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic          e_busy;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [DW-1:0] wd, input logic fl,
                                input logic rdy, input logic e_rd, input logic e_v,
                                input logic [DW-1:0] e_d, input logic e_l, input logic e_b);
        vec_t v;
        v.wr = wr; v.wd = wd; v.flush = fl; v.ready = rdy;
        v.e_rd = e_rd; v.e_valid = e_v; v.e_data = e_d; v.e_last = e_l; v.e_busy = e_b;
        return v;
    endfunction

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    // Scoreboard state for the randomized phase.
    logic [DW-1:0] exp_q[$];
    int            reqs;
    int            beats;
    int            written;
    logic          prev_stall;
    logic [DW:0]   prev_beat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; flush = 1'b0; inj_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // One observation point of the randomized run; m_ready already set for
    // the coming edge, so valid & ready here is a handshake at that edge.
    task automatic monitor_cycle();
        logic [DW-1:0] e;
        if (rd_en) begin
            reqs++;
            check("rd_en_nonempty", fifo_empty, 1'b0);
            check("credit_limit", (reqs - beats) <= 3, 1'b1);
        end
        if (prev_stall) begin
            check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_beat});
        end
        if (m_valid && m_ready) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rand_data", m_data, e);
                check("rand_last", m_last, (beats % FL) == FL - 1);
            end
            beats++;
        end
        prev_stall = m_valid & ~m_ready;
        prev_beat  = {m_last, m_data};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;

        // Single frame then flush frame, one row per clock.
        tbl[0]  = mk(H, 32'h10, L, H,  L, L, 32'h0,  L, L);
        tbl[1]  = mk(H, 32'h11, L, H,  L, L, 32'h0,  L, L);
        tbl[2]  = mk(H, 32'h12, L, H,  L, L, 32'h0,  L, L);
        tbl[3]  = mk(H, 32'h13, L, H,  L, L, 32'h0,  L, L);
        tbl[4]  = mk(L, 32'h0,  L, H,  H, L, 32'h0,  L, H);
        tbl[5]  = mk(L, 32'h0,  L, H,  H, L, 32'h0,  L, H);
        tbl[6]  = mk(L, 32'h0,  L, H,  H, H, 32'h10, L, H);
        tbl[7]  = mk(L, 32'h0,  L, H,  H, H, 32'h11, L, H);
        tbl[8]  = mk(L, 32'h0,  L, H,  L, H, 32'h12, L, H);
        tbl[9]  = mk(L, 32'h0,  L, H,  L, H, 32'h13, H, H);
        tbl[10] = mk(L, 32'h0,  L, H,  L, L, 32'h0,  L, L);
        tbl[11] = mk(L, 32'h0,  L, H,  L, L, 32'h0,  L, L);
        tbl[12] = mk(H, 32'hA0, L, H,  L, L, 32'h0,  L, L);
        tbl[13] = mk(H, 32'hA1, L, H,  L, L, 32'h0,  L, L);
        tbl[14] = mk(H, 32'hA2, L, H,  L, L, 32'h0,  L, L);
        tbl[15] = mk(L, 32'h0,  L, H,  L, L, 32'h0,  L, L);
        tbl[16] = mk(L, 32'h0,  H, H,  H, L, 32'h0,  L, H);
        tbl[17] = mk(L, 32'h0,  L, H,  H, L, 32'h0,  L, H);
        tbl[18] = mk(L, 32'h0,  L, H,  H, H, 32'hA0, L, H);
        tbl[19] = mk(L, 32'h0,  L, H,  L, H, 32'hA1, L, H);
        tbl[20] = mk(L, 32'h0,  L, H,  L, H, 32'hA2, H, H);
        tbl[21] = mk(L, 32'h0,  L, H,  L, L, 32'h0,  L, L);

        // Reset with random inputs for two cycles.
        rst = 1'b1; wr_data = '0;
        for (int i = 0; i < 2; i++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_data   = $urandom;
            flush     = 1'($urandom_range(0, 1));
            m_ready   = 1'($urandom_range(0, 1));
            inj_valid = 1'($urandom_range(0, 1));
            tick();
        end
        check("reset_outputs", {rd_en, m_valid, m_last, busy, err, m_data}, '0);
        rst = 1'b0; wr_en = 1'b0; flush = 1'b0; inj_valid = 1'b0; m_ready = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            wr_en = tbl[i].wr; wr_data = tbl[i].wd; flush = tbl[i].flush; m_ready = tbl[i].ready;
            tick();
            check($sformatf("vec%0d", i), {rd_en, m_valid, m_last, busy, err, m_data},
                  {tbl[i].e_rd, tbl[i].e_valid, tbl[i].e_last, tbl[i].e_busy, 1'b0, tbl[i].e_data});
        end
        wr_en = 1'b0; flush = 1'b0;

        // Unrequested read data: sticky error, buffer untouched.
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        check("err_set", err, 1'b1);
        check("err_buf_unchanged", m_valid, 1'b0);
        repeat (3) tick();
        check("err_sticky", err, 1'b1);
        do_reset();
        check("err_cleared", err, 1'b0);

        // Backpressure: 8 words, ready low -> exactly 3 requests.
        m_ready = 1'b0;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = (i < 8); wr_data = DW'(i);
            tick();
            if (rd_en) reqs++;
        end
        wr_en = 1'b0;
        check("bp_requests", reqs, 3);
        check("bp_hold", {m_valid, m_last, m_data}, {1'b1, 1'b0, 32'h0});
        m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            if (m_valid) begin
                check("bp_data", m_data, DW'(got));
                check("bp_last", m_last, (got % 4) == 3);
                got++;
            end
            tick();
        end
        check("bp_beats", got, 8);
        repeat (2) tick();
        check("bp_idle", {busy, m_valid, 1'(fifo_q.size() == 0)}, 3'b001);

        // Reset in the middle of a frame, then a clean frame.
        for (int i = 0; i < 4; i++) wr_word(32'h20 + DW'(i));
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (m_valid) got++;
            if (got < 2) tick();
        end
        check("mid_two_beats", got, 2);
        tick();
        rst = 1'b1;
        tick();
        check("mid_reset_outputs", {rd_en, m_valid, m_last, busy, err, m_data}, '0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) wr_word(32'h30 + DW'(i));
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            if (m_valid) begin
                check("mid_new_data", m_data, 32'h30 + DW'(got));
                check("mid_new_last", m_last, got == 3);
                got++;
            end
            tick();
        end
        check("mid_new_beats", got, 4);
        repeat (2) tick();
        check("mid_new_idle", busy, 1'b0);

        // Randomized traffic against the word-order / framing scoreboard.
        do_reset();
        exp_q.delete();
        reqs = 0; beats = 0; written = 0; prev_stall = 1'b0; prev_beat = '0;
        for (int c = 0; c < 3000; c++) begin
            if (fifo_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                wr_en = 1'b1; wr_data = $urandom;
                exp_q.push_back(wr_data);
                written++;
            end else begin
                wr_en = 1'b0;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            monitor_cycle();
            tick();
        end
        wr_en = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            monitor_cycle();
            tick();
        end
        check("rand_leftover", exp_q.size(), written % FL);
        check("rand_no_err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_stream_reader
